clk_manager: RTL
================

CLK_MANAGER -- requirements
Module: clk_manager

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent clock-enable outputs, legal range 1..8.
REQ-002 Parameter DIV_WIDTH, default 8: width of each per-channel divisor.
REQ-003 Parameter LOCK_CYCLES, default 1024: consecutive synchronised-lock cycles required before release, legal range 2 or more.
REQ-004 Parameter SYNC_STAGES, default 2: flop count of the lock synchroniser, legal range 2..4.
REQ-005 clock  input  1  sole clock; the PLL output drives it.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pll_locked  input  1  raw PLL lock flag, asynchronous to clock.
REQ-008 div  input  CHANNELS*DIV_WIDTH  divisor per channel; channel i occupies bits [i*DIV_WIDTH +: DIV_WIDTH].
REQ-009 div_load  input  1  one-cycle strobe that captures div into the shadow registers.
REQ-010 ce_out  output  CHANNELS  per-channel single-cycle clock-enable pulses, e.g. the pixel enable.
REQ-011 rst_out  output  1  synchronous active-high reset for downstream logic.
REQ-012 ready  output  1  high only in RUN.
REQ-013 loss_count  output  8  count of lock-loss events; present only under CLK_MANAGER_LOSS_COUNT_EN.

Function
REQ-014 pll_locked SHALL pass through a SYNC_STAGES flop chain to give locked_s; the FSM SHALL use only locked_s.
REQ-015 FSM states SHALL be WAIT_LOCK, STABILIZE, RUN and LOST.
REQ-016 WAIT_LOCK: if locked_s=1, SHALL go to STABILIZE and clear the stability counter.
REQ-017 STABILIZE: the counter SHALL increment each cycle; locked_s=0 SHALL return to WAIT_LOCK; counter==LOCK_CYCLES-1 with locked_s=1 SHALL go to RUN.
REQ-018 RUN SHALL therefore be entered exactly LOCK_CYCLES cycles after STABILIZE is entered, given uninterrupted lock.
REQ-019 RUN: locked_s=0 SHALL go to LOST; LOST SHALL last exactly one cycle, then go to WAIT_LOCK.
REQ-020 rst_out SHALL be 1 in every state except RUN; ready SHALL equal (state==RUN); both SHALL be registered.
REQ-021 Each channel SHALL have a DIV_WIDTH counter, held at 0 outside RUN; in RUN, ce_out[i]=1 when count_i==div_i, after which count_i wraps to 0, giving one pulse every div_i+1 cycles.
REQ-022 A channel with div_i=0 SHALL drive ce_out[i]=1 on every RUN cycle; a channel with div_i at its maximum value SHALL pulse every 2^DIV_WIDTH cycles with no overflow.
REQ-023 ce_out SHALL be 0 in every non-RUN cycle, including the cycle in which the FSM leaves RUN.
REQ-024 div_load SHALL update the shadow registers; outside RUN the new value SHALL take effect immediately.
REQ-025 div_load in RUN SHALL take effect per channel at that channel's next wrap; if the load and the wrap fall in the same cycle, the current pulse SHALL be emitted and the next period SHALL use the new divisor.

Reset
REQ-026 reset SHALL give: state=WAIT_LOCK, rst_out=1, ready=0, ce_out=0, all counters 0, synchroniser flops 0, shadow divisors 0, loss_count=0.
REQ-027 reset asserted in any state, including mid-RUN, SHALL take effect on the next edge with no LOST cycle and no loss_count increment.

Configuration
REQ-028 With CLK_MANAGER_LOSS_COUNT_EN defined, loss_count SHALL increment on each LOST cycle and saturate at 255.
REQ-029 Without CLK_MANAGER_LOSS_COUNT_EN, the loss_count port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package clk_manager_pkg SHALL hold the FSM state enum and the LOSS_COUNT_W=8 constant.
REQ-031 The synchroniser SHALL be a separate sub-module, sync_ff, parametrised by stage count.

Verification (LOCK_CYCLES=16, SYNC_STAGES=2, CHANNELS=2, DIV_WIDTH=8)
REQ-032 Stimulus: pll_locked rises at cycle 10. Response: ready and rst_out change at cycle 10+2+1+16, within ±0 cycles.
REQ-033 Stimulus: locked dropped for 1 cycle midway through STABILIZE. Response: returns to WAIT_LOCK; the full 16-cycle count restarts once lock returns.
REQ-034 Stimulus: in RUN, div={ch1=3, ch0=0}. Response: ce_out[0] is constantly 1; ce_out[1] pulses every 4 cycles with its first pulse 3 cycles after RUN entry.
REQ-035 Stimulus: in RUN, div_load with ch1 changed from 3 to 1. Response: the remaining period stays 4 cycles, then pulses come every 2 cycles; there is no runt pulse.
REQ-036 Stimulus: lock lost in RUN three times, then lock lost 300 times. Response: loss_count reads 3, then saturates at 255; each loss gives exactly one LOST cycle with ce_out=0.
REQ-037 Stimulus: reset pulsed mid-RUN. Response: all outputs take their reset values the next cycle, and loss_count is unchanged from 0 after reset.

Source files
------------

// File: rtl/clk_manager_pkg.sv
// clk_manager_pkg: shared types and constants for the clock manager.
//   state_e      - lock-tracking FSM states
//   LOSS_COUNT_W - width of the lock-loss counter (used when
//                  CLK_MANAGER_LOSS_COUNT_EN is defined)
package clk_manager_pkg;

   localparam int unsigned LOSS_COUNT_W = 8;

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABILIZE = 2'd1,
      ST_RUN       = 2'd2,
      ST_LOST      = 2'd3
   } state_e;

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for a single asynchronous bit.
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, clears every stage
//   d_i   - asynchronous input
//   q_o   - synchronised output (last stage)
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_manager.sv
// clk_manager: waits for a stable PLL lock, then releases downstream reset
// and generates per-channel clock-enable pulses from programmable divisors.
//   clock      - PLL output clock (sole clock)
//   reset      - synchronous active-high reset
//   pll_locked - raw asynchronous PLL lock flag
//   div        - per-channel divisor, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   div_load   - one-cycle strobe capturing div into the shadow registers
//   ce_out     - per-channel enable, one pulse every div_i+1 RUN cycles
//   rst_out    - active-high downstream reset, low only in RUN
//   ready      - high only in RUN
//   loss_count - saturating lock-loss counter, present only when
//                CLK_MANAGER_LOSS_COUNT_EN is defined
module clk_manager
   import clk_manager_pkg::*;
#(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned DIV_WIDTH   = 8,
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          pll_locked,
   input  logic [CHANNELS*DIV_WIDTH-1:0] div,
   input  logic                          div_load,
   output logic [CHANNELS-1:0]           ce_out,
   output logic                          rst_out,
   output logic                          ready
`ifdef CLK_MANAGER_LOSS_COUNT_EN
   ,
   output logic [LOSS_COUNT_W-1:0]       loss_count
`endif
);

   localparam int unsigned STAB_W = $clog2(LOCK_CYCLES);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_CYCLES - 1);

   logic        locked_s;
   state_e      state_q, state_d;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic        ready_q, ready_d;
   logic        rst_out_q, rst_out_d;
   logic        run_q, run_d;

   logic [CHANNELS-1:0][DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0][DIV_WIDTH-1:0] act_q, act_d;
   logic [CHANNELS-1:0][DIV_WIDTH-1:0] shd_q, shd_d;
   logic [CHANNELS-1:0]                ce_q, ce_d;

   // Lock flag synchroniser; the FSM only ever looks at locked_s.
   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clock),
      .rst_i (reset),
      .d_i   (pll_locked),
      .q_o   (locked_s)
   );

   // State and stability counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_WAIT_LOCK;
         stab_q  <= '0;
      end else begin
         state_q <= state_d;
         stab_q  <= stab_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_STABILIZE;
               stab_d  = '0;
            end
         end
         ST_STABILIZE: begin
            if (!locked_s)                state_d = ST_WAIT_LOCK;
            else if (stab_q == STAB_LAST) state_d = ST_RUN;
            else                          stab_d  = stab_q + STAB_W'(1);
         end
         ST_RUN: begin
            if (!locked_s) state_d = ST_LOST;
         end
         ST_LOST:  state_d = ST_WAIT_LOCK;
         default:  state_d = ST_WAIT_LOCK;
      endcase
   end

   // Output decode from the next state so the registered outputs track state_q.
   always_comb begin
      ready_d   = 1'b0;
      rst_out_d = 1'b1;
      if (state_d == ST_RUN) begin
         ready_d   = 1'b1;
         rst_out_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ready_q   <= 1'b0;
         rst_out_q <= 1'b1;
      end else begin
         ready_q   <= ready_d;
         rst_out_q <= rst_out_d;
      end
   end

   assign run_q = (state_q == ST_RUN);
   assign run_d = (state_d == ST_RUN);

   // Divider channels. act_q is the divisor for the current period; it picks
   // up the shadow (or a same-cycle load) only when a new period starts, so a
   // reload in RUN never cuts a period short. ce is registered by looking
   // ahead at the next count/divisor pair.
   always_comb begin
      cnt_d = cnt_q;
      act_d = act_q;
      shd_d = shd_q;
      ce_d  = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (div_load) shd_d[i] = div[i*DIV_WIDTH +: DIV_WIDTH];
         if (!run_d || !run_q || (cnt_q[i] == act_q[i])) begin
            cnt_d[i] = '0;
            act_d[i] = shd_d[i];
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
         end
         ce_d[i] = run_d && (cnt_d[i] == act_d[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
         act_q <= '0;
         shd_q <= '0;
         ce_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         act_q <= act_d;
         shd_q <= shd_d;
         ce_q  <= ce_d;
      end
   end

   assign ce_out  = ce_q;
   assign rst_out = rst_out_q;
   assign ready   = ready_q;

`ifdef CLK_MANAGER_LOSS_COUNT_EN
   logic [LOSS_COUNT_W-1:0] loss_q;

   // Counts entries into LOST; saturates at all-ones.
   always_ff @(posedge clock) begin
      if (reset) begin
         loss_q <= '0;
      end else if ((state_d == ST_LOST) && (loss_q != '1)) begin
         loss_q <= loss_q + LOSS_COUNT_W'(1);
      end
   end

   assign loss_count = loss_q;
`endif

endmodule
